// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  function automatic logic presc_legal(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-cell timing for the receiver: edge counter, three mid-cell samples and
// the majority vote, resolved on the last cycle of each cell.
module uart_rx_sampler #(
  parameter int PRESC_WD = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                run,
  input  logic                start,
  input  logic [PRESC_WD-1:0] presc,
  input  logic                rx_in,
  output logic                bit_val,
  output logic                bit_done
);

  logic [PRESC_WD-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]          smp_q, smp_d;
  logic [PRESC_WD-1:0] half;
  logic [PRESC_WD-1:0] last;

  assign half = presc >> 1;
  assign last = presc - PRESC_WD'(1);

  // The start-detect cycle is cell cycle 0, so the count resumes at 1.
  always_comb begin
    edge_cnt_d = '0;
    if (start) begin
      edge_cnt_d = PRESC_WD'(1);
    end else if (run) begin
      edge_cnt_d = (edge_cnt_q == last) ? '0 : edge_cnt_q + PRESC_WD'(1);
    end
  end

  always_comb begin
    smp_d = smp_q;
    if (run) begin
      if (edge_cnt_q == half - PRESC_WD'(1)) smp_d[0] = rx_in;
      if (edge_cnt_q == half)                smp_d[1] = rx_in;
      if (edge_cnt_q == half + PRESC_WD'(1)) smp_d[2] = rx_in;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

  assign bit_val  = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  assign bit_done = run && (edge_cnt_q == last);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled frame deserialiser with optional parity and
// registered one-cycle result pulses.
module uart_rx #(
  parameter int Data_WD  = 8,
  parameter int PRESC_WD = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic [PRESC_WD-1:0] prescale,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  output logic [Data_WD-1:0]  P_DATA,
  output logic                Data_Valid,
  output logic                par_err,
  output logic                stp_err
);
  import uart_pkg::*;

  // state     | meaning
  // ST_IDLE   | line idle, waiting for a low level
  // ST_START  | start cell; a high majority is a glitch
  // ST_DATA   | Data_WD data cells, LSB first
  // ST_PARITY | parity cell, mismatch recorded
  // ST_STOP   | stop cell, frame outcome decided at cell end

  localparam int CNT_WD = $clog2(Data_WD + 1);

  rx_state_e           state_q, state_d;
  logic [PRESC_WD-1:0] presc_q, presc_d;
  logic                par_en_q, par_en_d;
  logic                par_typ_q, par_typ_d;
  logic [CNT_WD-1:0]   bit_cnt_q, bit_cnt_d;
  logic [Data_WD-1:0]  shift_q, shift_d;
  logic                perr_flag_q, perr_flag_d;
  logic [Data_WD-1:0]  pdata_q, pdata_d;
  logic                dv_q, dv_d;
  logic                perr_q, perr_d;
  logic                serr_q, serr_d;
  logic                frame_start;
  logic                par_exp;
  logic                bit_val;
  logic                bit_done;

  assign frame_start = (state_q == ST_IDLE) && !RX_IN;

  uart_rx_sampler #(.PRESC_WD(PRESC_WD)) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .run      (state_q != ST_IDLE),
    .start    (frame_start),
    .presc    (presc_q),
    .rx_in    (RX_IN),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!RX_IN) state_d = ST_START;
      ST_START:  if (bit_done) state_d = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_done && bit_cnt_q == CNT_WD'(Data_WD - 1))
                   state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_d = ST_STOP;
      ST_STOP:   if (bit_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d     = presc_q;
    par_en_d    = par_en_q;
    par_typ_d   = par_typ_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    perr_flag_d = perr_flag_q;
    pdata_d     = pdata_q;
    dv_d        = 1'b0;
    perr_d      = 1'b0;
    serr_d      = 1'b0;
    par_exp     = (par_typ_q == PAR_EVEN) ? ^shift_q : ~(^shift_q);
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          presc_d     = prescale;
          par_en_d    = PAR_EN;
          par_typ_d   = PAR_TYP;
          bit_cnt_d   = '0;
          perr_flag_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d   = {bit_val, shift_q[Data_WD-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_WD'(1);
        end
      end
      ST_PARITY: begin
        if (bit_done && (bit_val != par_exp)) perr_flag_d = 1'b1;
      end
      ST_STOP: begin
        if (bit_done) begin
          serr_d = ~bit_val;
          perr_d = perr_flag_q;
          dv_d   = bit_val & ~perr_flag_q;
          if (bit_val && !perr_flag_q) pdata_d = shift_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_q     <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      perr_flag_q <= 1'b0;
      pdata_q     <= '0;
      dv_q        <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      par_en_q    <= par_en_d;
      par_typ_q   <= par_typ_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      perr_flag_q <= perr_flag_d;
      pdata_q     <= pdata_d;
      dv_q        <= dv_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
    end
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign par_err    = perr_q;
  assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner
// sequences, with expected result pulses scoreboarded by cycle.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       par_err;
  logic       stp_err;

  always #5 CLK = ~CLK;

  uart_rx #(.Data_WD(8), .PRESC_WD(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  typedef struct {
    int         p;
    bit         pe;
    bit         pt;
    logic [7:0] data;
    bit         bad_par;
    bit         stop;
    int         corrupt;
    bit         scramble;
    int         gap;
    bit         exp_dv;
    bit         exp_perr;
    bit         exp_serr;
  } vec_t;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         perr;
    bit         serr;
    logic [7:0] pdata;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[10];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  // cyc+1 is the index of the cycle that ends at the next rising edge.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b0 && (Data_Valid === 1'b1 || par_err === 1'b1 || stp_err === 1'b1)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: cycle %0d dv %0b perr %0b serr %0b, expected no pulse",
                 cyc + 1, Data_Valid, par_err, stp_err);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc + 1, e.cyc);
        chk("data_valid", Data_Valid, e.dv);
        chk("par_err", par_err, e.perr);
        chk("stp_err", stp_err, e.serr);
        chk("p_data", P_DATA, e.pdata);
      end
    end
  end

  task automatic send_cell(input logic v, input int p, input int glitch_k);
    for (int k = 0; k < p; k++) begin
      RX_IN = (k == glitch_k) ? ~v : v;
      @(negedge CLK);
    end
  endtask

  task automatic send_frame(input vec_t v);
    exp_t e;
    logic par;
    int   n;
    prescale = 6'(v.p);
    PAR_EN   = v.pe;
    PAR_TYP  = v.pt;
    n        = (2 + 8 + (v.pe ? 1 : 0)) * v.p;
    e.cyc    = cyc + 1 + n;
    e.dv     = v.exp_dv;
    e.perr   = v.exp_perr;
    e.serr   = v.exp_serr;
    if (v.exp_dv) last_good = v.data;
    e.pdata  = last_good;
    sb.push_back(e);
    send_cell(1'b0, v.p, -1);
    if (v.scramble) begin
      prescale = (v.p == 32) ? 6'd8 : 6'd32;
      PAR_EN   = ~v.pe;
      PAR_TYP  = ~v.pt;
    end
    for (int i = 0; i < 8; i++)
      send_cell(v.data[i], v.p, (i == v.corrupt) ? (v.p / 2 - 1) : -1);
    par = (^v.data) ^ v.pt ^ v.bad_par;
    if (v.pe) send_cell(par, v.p, -1);
    send_cell(v.stop, v.p, -1);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge CLK);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d pulses still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic vec_t mk(input int p, input bit pe, input bit pt, input logic [7:0] d,
                              input bit bad_par, input bit stop, input int corrupt,
                              input bit scramble, input int gap);
    vec_t v;
    v.p = p; v.pe = pe; v.pt = pt; v.data = d; v.bad_par = bad_par; v.stop = stop;
    v.corrupt = corrupt; v.scramble = scramble; v.gap = gap;
    v.exp_dv   = stop && !(pe && bad_par);
    v.exp_perr = pe && bad_par;
    v.exp_serr = !stop;
    return v;
  endfunction

  initial begin
    vecs[0] = mk(8,  0, 0, 8'hA5, 0, 1, -1, 0, 3);
    vecs[1] = mk(16, 1, 0, 8'h3C, 1, 1, -1, 0, 2);
    vecs[2] = mk(8,  0, 0, 8'h81, 0, 0, -1, 0, 2);
    vecs[3] = mk(8,  0, 0, 8'h3C, 0, 1, -1, 0, 0);
    vecs[4] = mk(16, 1, 1, 8'h12, 0, 1, -1, 0, 4);
    vecs[5] = mk(16, 1, 1, 8'hFE, 0, 1,  3, 0, 0);
    vecs[6] = mk(32, 1, 0, 8'hC3, 0, 1, -1, 1, 2);
    vecs[7] = mk(16, 1, 1, 8'h5A, 1, 0, -1, 0, 2);
    vecs[8] = mk(32, 0, 0, 8'h00, 0, 1,  5, 0, 1);
    vecs[9] = mk(8,  1, 0, 8'hFF, 0, 1, -1, 1, 0);

    RST = 1'b1; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_p_data", P_DATA, 8'h00);
    chk("reset_data_valid", Data_Valid, 1'b0);
    chk("reset_par_err", par_err, 1'b0);
    chk("reset_stp_err", stp_err, 1'b0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].gap > 0) begin
        RX_IN = 1'b1;
        repeat (vecs[i].gap) @(negedge CLK);
      end
      send_frame(vecs[i]);
    end
    RX_IN = 1'b1;
    drain();

    // Short low pulse: the start cell majority is high, so no frame.
    prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (5) @(negedge CLK);
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (30) @(negedge CLK);
    send_frame(mk(16, 0, 0, 8'h55, 0, 1, -1, 0, 0));
    RX_IN = 1'b1;
    drain();
    chk("after_glitch_p_data", P_DATA, 8'h55);

    // Reset in the middle of the data bits.
    repeat (4) @(negedge CLK);
    prescale = 6'd16; PAR_EN = 1'b0;
    send_cell(1'b0, 16, -1);
    send_cell(1'b1, 16, -1);
    send_cell(1'b0, 16, -1);
    send_cell(1'b1, 5, -1);
    RST = 1'b1;
    #1;
    chk("midreset_p_data", P_DATA, 8'h00);
    chk("midreset_data_valid", Data_Valid, 1'b0);
    chk("midreset_par_err", par_err, 1'b0);
    chk("midreset_stp_err", stp_err, 1'b0);
    @(negedge CLK);
    RX_IN = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    last_good = 8'h00;
    repeat (200) @(negedge CLK);
    send_frame(mk(8, 0, 0, 8'h7E, 0, 1, -1, 0, 0));
    RX_IN = 1'b1;
    drain();
    repeat (20) @(negedge CLK);
    chk("final_p_data", P_DATA, 8'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
